// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: sentinel encodings, unit opcodes, tag width
// and the load functional unit state encoding.
package tomasulo_pkg;

  localparam int unsigned TAG_W = 3;

  // Sentinels for "no value" on the data bus, tag bus and address bus.
  localparam logic [15:0]      DATA_NONE = 16'hFFF0;
  localparam logic [TAG_W-1:0] TAG_NONE  = 3'b000;
  localparam logic [6:0]       A_NONE    = 7'b1111000;

  localparam logic [2:0] UFOP_LOAD = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCdb,
    StHold
  } uf_load_state_e;

endpackage

// File: rtl/uf_load.sv
// Load functional unit. Accepts a base (Op1) and offset (Op2) from the LOAD
// operand selector, issues one data-memory read at Op1+Op2, waits a fixed
// memory latency, then broadcasts the loaded word on the CDB tagged with the
// issuing reservation station. After the broadcast it pulses Rs_free and
// ignores Ready_to_uf for HOLDOFF cycles so the selector's stale request
// cannot start a second load.
//
// Ports:
//   Clock, Reset        clock; asynchronous active-high reset
//   Ready_to_uf         operands valid from the selector
//   Op1, Op2, Rs_tag    base, offset and issuing station tag (0 = none)
//   Mem_rd, Mem_addr    one-cycle read strobe and held read address
//   Mem_rdata           read data, valid MEM_LATENCY cycles after Mem_rd
//   Cdb_req, Cdb_grant  CDB request / grant handshake
//   Qi_CDB, Qi_CDB_data broadcast tag and data (sentinels when idle)
//   Uf_busy             unit not idle
//   Rs_free             one-cycle completion pulse to the station
// All outputs are registered.
module uf_load
  import tomasulo_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Ready_to_uf,
  input  logic [DATA_W-1:0] Op1,
  input  logic [DATA_W-1:0] Op2,
  input  logic [TAG_W-1:0]  Rs_tag,
  output logic              Mem_rd,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [DATA_W-1:0] Mem_rdata,
  output logic              Cdb_req,
  input  logic              Cdb_grant,
  output logic [TAG_W-1:0]  Qi_CDB,
  output logic [DATA_W-1:0] Qi_CDB_data,
  output logic              Uf_busy,
  output logic              Rs_free
);

  localparam logic [DATA_W-1:0] DataNone = DATA_W'(DATA_NONE);

  // One counter serves both the memory latency and the holdoff window.
  localparam int unsigned CntMax = (MEM_LATENCY > HOLDOFF) ? MEM_LATENCY - 1 : HOLDOFF - 1;
  localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntLatency = CntW'(MEM_LATENCY - 1);
  localparam logic [CntW-1:0] CntHoldoff = CntW'(HOLDOFF - 1);

  uf_load_state_e    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              req_q, req_d;
  logic [TAG_W-1:0]  qtag_q, qtag_d;
  logic [DATA_W-1:0] qdata_q, qdata_d;
  logic              busy_q, busy_d;
  logic              free_q, free_d;

  logic              accept;
  logic [ADDR_W-1:0] ea;

  assign accept = Ready_to_uf && (Op1 != DataNone) && (Op2 != DataNone) && (Rs_tag != TAG_NONE);

  // Low ADDR_W bits of a wrapping sum depend only on the low ADDR_W bits of
  // the operands.
  assign ea = Op1[ADDR_W-1:0] + Op2[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    req_d   = 1'b0;
    qtag_d  = TAG_NONE;
    qdata_d = DataNone;
    free_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          tag_d   = Rs_tag;
          addr_d  = ea;
          rd_d    = 1'b1;
        end
      end

      StIssue: begin
        cnt_d   = CntLatency;
        state_d = StWait;
      end

      StWait: begin
        if (cnt_q == '0) begin
          // Qi_CDB_data doubles as the captured-data register.
          state_d = StCdb;
          req_d   = 1'b1;
          qtag_d  = tag_q;
          qdata_d = Mem_rdata;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StCdb: begin
        if (Cdb_grant) begin
          state_d = StHold;
          cnt_d   = CntHoldoff;
          free_d  = 1'b1;
        end else begin
          req_d   = 1'b1;
          qtag_d  = qtag_q;
          qdata_d = qdata_q;
        end
      end

      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tag_q   <= TAG_NONE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      req_q   <= 1'b0;
      qtag_q  <= TAG_NONE;
      qdata_q <= DataNone;
      busy_q  <= 1'b0;
      free_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      qtag_q  <= qtag_d;
      qdata_q <= qdata_d;
      busy_q  <= busy_d;
      free_q  <= free_d;
    end
  end

  assign Mem_rd      = rd_q;
  assign Mem_addr    = addr_q;
  assign Cdb_req     = req_q;
  assign Qi_CDB      = qtag_q;
  assign Qi_CDB_data = qdata_q;
  assign Uf_busy     = busy_q;
  assign Rs_free     = free_q;

endmodule

// File: tb/tb_uf_load.sv
// Bench for uf_load: instance A uses default parameters, instance B uses
// MEM_LATENCY=3. Stimulus pushes expected events (read strobe, broadcast,
// Rs_free) with their cycle stamps; a negedge monitor pops and compares.
module tb_uf_load;

  localparam int EvRd   = 0;
  localparam int EvBc   = 1;
  localparam int EvFree = 2;

  typedef struct {
    int          dut;
    int          kind;
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  e0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        rdy_a, rdy_b;
  logic [15:0] Op1, Op2;
  logic [2:0]  Rs_tag;
  logic        gnt_a, gnt_b;
  logic [15:0] rdata_a, rdata_b;

  logic [1:0]  mrd, creq, gnt, rfree, busy;
  logic [6:0]  maddr [2];
  logic [2:0]  qtag  [2];
  logic [15:0] qdata [2];

  logic [15:0] mem [128];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign gnt = {gnt_b, gnt_a};

  uf_load u_dut_a (
    .Clock       (Clock),
    .Reset       (Reset),
    .Ready_to_uf (rdy_a),
    .Op1         (Op1),
    .Op2         (Op2),
    .Rs_tag      (Rs_tag),
    .Mem_rd      (mrd[0]),
    .Mem_addr    (maddr[0]),
    .Mem_rdata   (rdata_a),
    .Cdb_req     (creq[0]),
    .Cdb_grant   (gnt_a),
    .Qi_CDB      (qtag[0]),
    .Qi_CDB_data (qdata[0]),
    .Uf_busy     (busy[0]),
    .Rs_free     (rfree[0])
  );

  uf_load #(.MEM_LATENCY(3)) u_dut_b (
    .Clock       (Clock),
    .Reset       (Reset),
    .Ready_to_uf (rdy_b),
    .Op1         (Op1),
    .Op2         (Op2),
    .Rs_tag      (Rs_tag),
    .Mem_rd      (mrd[1]),
    .Mem_addr    (maddr[1]),
    .Mem_rdata   (rdata_b),
    .Cdb_req     (creq[1]),
    .Cdb_grant   (gnt_b),
    .Qi_CDB      (qtag[1]),
    .Qi_CDB_data (qdata[1]),
    .Uf_busy     (busy[1]),
    .Rs_free     (rfree[1])
  );

  // Memory models: data is valid only in the exact cycle the latency allows.
  logic       pa_v;
  logic [6:0] pa_addr;
  logic [2:0] pb_v;
  logic [6:0] pb_addr [3];

  always @(posedge Clock) begin
    pa_v       <= mrd[0];
    pa_addr    <= maddr[0];
    pb_v       <= {pb_v[1:0], mrd[1]};
    pb_addr[0] <= maddr[1];
    pb_addr[1] <= pb_addr[0];
    pb_addr[2] <= pb_addr[1];
  end

  assign rdata_a = pa_v    ? mem[pa_addr]    : 16'h0BAD;
  assign rdata_b = pb_v[2] ? mem[pb_addr[2]] : 16'h0BAD;

  task automatic expect_ev(input int d, input int k, input int c, input logic [15:0] a,
                           input logic [15:0] b);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = c; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic note(input int d, input int k, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: dut=%0d kind=%0d cyc=%0d a=%h b=%h, none expected",
               d, k, cyc, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || e.cyc != cyc || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL event: got dut=%0d kind=%0d cyc=%0d a=%h b=%h, want dut=%0d kind=%0d cyc=%0d a=%h b=%h",
                 d, k, cyc, a, b, e.dut, e.kind, e.cyc, e.a, e.b);
      end
    end
  endtask

  always @(negedge Clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mrd[d])              note(d, EvRd, {9'b0, maddr[d]}, 16'h0000);
      if (creq[d] && gnt[d])   note(d, EvBc, {13'b0, qtag[d]}, qdata[d]);
      if (rfree[d])            note(d, EvFree, 16'h0000, 16'h0000);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag, input int d);
    chk({tag, "_mem_rd"},  32'(mrd[d]),   32'h0);
    chk({tag, "_addr"},    32'(maddr[d]), 32'h0);
    chk({tag, "_req"},     32'(creq[d]),  32'h0);
    chk({tag, "_qtag"},    32'(qtag[d]),  32'h0);
    chk({tag, "_qdata"},   32'(qdata[d]), 32'hFFF0);
    chk({tag, "_busy"},    32'(busy[d]),  32'h0);
    chk({tag, "_rs_free"}, 32'(rfree[d]), 32'h0);
  endtask

  task automatic chk_cdb_a(input string tag, input logic req, input logic [2:0] t,
                           input logic [15:0] dat);
    chk({tag, "_req"},   32'(creq[0]),  32'(req));
    chk({tag, "_qtag"},  32'(qtag[0]),  32'(t));
    chk({tag, "_qdata"}, 32'(qdata[0]), 32'(dat));
  endtask

  initial begin
    Reset = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    Op1 = '0; Op2 = '0; Rs_tag = '0; gnt_a = 1'b1; gnt_b = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h5A00 ^ 16'(i);
    mem[7'h15] = 16'hBEEF;
    mem[7'h23] = 16'h1234;
    mem[7'h01] = 16'hCAFE;

    step(); step();
    chk_reset_vals("rst_a", 0);
    chk_reset_vals("rst_b", 1);
    Reset = 1'b0;
    step();

    // Basic load with immediate grant.
    Op1 = 16'h0010; Op2 = 16'h0005; Rs_tag = 3'd2; rdy_a = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, EvRd,   e0,     16'h0015, 16'h0000);
    expect_ev(0, EvBc,   e0 + 2, 16'h0002, 16'hBEEF);
    expect_ev(0, EvFree, e0 + 3, 16'h0000, 16'h0000);
    step();
    rdy_a = 1'b0;
    chk("basic_busy", 32'(busy[0]), 32'h1);
    chk("basic_addr", 32'(maddr[0]), 32'h15);
    repeat (7) step();
    chk("basic_idle", 32'(busy[0]), 32'h0);

    // Grant withheld for three cycles.
    gnt_a = 1'b0; rdy_a = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, EvRd,   e0,     16'h0015, 16'h0000);
    expect_ev(0, EvBc,   e0 + 5, 16'h0002, 16'hBEEF);
    expect_ev(0, EvFree, e0 + 6, 16'h0000, 16'h0000);
    step();
    rdy_a = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk_cdb_a("stall_hold", 1'b1, 3'd2, 16'hBEEF);
      step();
    end
    chk_cdb_a("stall_grant", 1'b1, 3'd2, 16'hBEEF);
    gnt_a = 1'b1;
    step();
    chk_cdb_a("stall_after", 1'b0, 3'd0, 16'hFFF0);
    chk("stall_rs_free", 32'(rfree[0]), 32'h1);
    repeat (6) step();

    // Ready_to_uf held high: second accept only after the holdoff window.
    rdy_a = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, EvRd,   e0,     16'h0015, 16'h0000);
    expect_ev(0, EvBc,   e0 + 2, 16'h0002, 16'hBEEF);
    expect_ev(0, EvFree, e0 + 3, 16'h0000, 16'h0000);
    expect_ev(0, EvRd,   e0 + 6, 16'h0015, 16'h0000);
    expect_ev(0, EvBc,   e0 + 8, 16'h0002, 16'hBEEF);
    expect_ev(0, EvFree, e0 + 9, 16'h0000, 16'h0000);
    repeat (7) step();
    rdy_a = 1'b0;
    repeat (6) step();

    // Fresh request with different operands and tag.
    Op1 = 16'h0020; Op2 = 16'h0003; Rs_tag = 3'd5; rdy_a = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, EvRd,   e0,     16'h0023, 16'h0000);
    expect_ev(0, EvBc,   e0 + 2, 16'h0005, 16'h1234);
    expect_ev(0, EvFree, e0 + 3, 16'h0000, 16'h0000);
    step();
    rdy_a = 1'b0;
    repeat (6) step();

    // Sentinel operands and null tag are refused.
    Op1 = 16'hFFF0; Op2 = 16'h0005; Rs_tag = 3'd3; rdy_a = 1'b1;
    repeat (3) step();
    chk("rej_op1_busy", 32'(busy[0]), 32'h0);
    Op1 = 16'h0010; Op2 = 16'hFFF0;
    repeat (3) step();
    chk("rej_op2_busy", 32'(busy[0]), 32'h0);
    Op2 = 16'h0005; Rs_tag = 3'd0;
    repeat (3) step();
    chk("rej_tag_busy", 32'(busy[0]), 32'h0);
    chk("rej_tag_req", 32'(creq[0]), 32'h0);
    rdy_a = 1'b0;
    step();

    // Reset while waiting on memory drops the load.
    Rs_tag = 3'd2; rdy_a = 1'b1;
    e0 = cyc + 1;
    expect_ev(0, EvRd, e0, 16'h0015, 16'h0000);
    step();
    rdy_a = 1'b0;
    step();
    chk("midrst_busy_before", 32'(busy[0]), 32'h1);
    Reset = 1'b1;
    #1;
    chk_reset_vals("midrst", 0);
    step();
    Reset = 1'b0;
    repeat (6) step();
    chk("midrst_idle", 32'(busy[0]), 32'h0);

    // Address wrap with three-cycle memory latency.
    Op1 = 16'hFFFF; Op2 = 16'h0002; Rs_tag = 3'd4; rdy_b = 1'b1;
    e0 = cyc + 1;
    expect_ev(1, EvRd,   e0,     16'h0001, 16'h0000);
    expect_ev(1, EvBc,   e0 + 4, 16'h0004, 16'hCAFE);
    expect_ev(1, EvFree, e0 + 5, 16'h0000, 16'h0000);
    step();
    rdy_b = 1'b0;
    chk("wrap_addr", 32'(maddr[1]), 32'h01);
    repeat (9) step();
    chk("wrap_idle", 32'(busy[1]), 32'h0);

    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uf_load.md
# uf_load

Load functional unit of the Tomasulo core, directly downstream of the LOAD operand selector. It accepts resolved operands (base in Op1, offset in Op2) when the selector raises Ready_to_uf, issues one read to data memory at Op1+Op2, and waits a fixed memory latency. It then arbitrates for the CDB and broadcasts the loaded word tagged with the issuing reservation station. It pulses Rs_free so the station clears Busy, then holds off re-acceptance until the selector's stale Ready_to_uf has dropped.

## Interface
- DATA_W, 16, operand/data width
- ADDR_W, 7, data memory address width
- MEM_LATENCY, 1, cycles from the Mem_rd cycle to Mem_rdata valid (≥1)
- HOLDOFF, 2, idle cycles after completion during which Ready_to_uf is ignored
- Clock  in  1  system clock
- Reset  in  1  reset Reset, asynchronous, active-high; clock Clock
- Ready_to_uf  in  1  operands valid from selector
- Op1  in  DATA_W  base address operand
- Op2  in  DATA_W  offset operand (A, zero-extended)
- Rs_tag  in  3  tag of issuing reservation station; 3'b000 = none
- Mem_rd  out  1  one-cycle read strobe
- Mem_addr  out  ADDR_W  read address
- Mem_rdata  in  DATA_W  read data
- Cdb_req  out  1  CDB request
- Cdb_grant  in  1  CDB grant from arbiter
- Qi_CDB  out  3  broadcast tag
- Qi_CDB_data  out  DATA_W  broadcast data
- Uf_busy  out  1  unit not in IDLE
- Rs_free  out  1  one-cycle completion pulse to the reservation station

## Operation
- States: IDLE, ISSUE, WAIT, CDB, HOLD. Outputs are registered.
- IDLE: accept on an edge where Ready_to_uf=1, Op1≠16'hFFF0, Op2≠16'hFFF0, and Rs_tag≠0.
  - On accept, latch the tag and set Mem_addr = (Op1+Op2) mod 2^16, truncated to the low ADDR_W bits.
  - Next state is ISSUE. Any failing condition leaves the unit in IDLE with no side effect.
- ISSUE: Mem_rd=1 for exactly this cycle. At the edge, load cnt=MEM_LATENCY-1 and go to WAIT.
- WAIT: Mem_rd=0 and Mem_addr held. On each edge, if cnt==0, capture Mem_rdata into the data register and go to CDB; otherwise decrement cnt.
- CDB: Cdb_req=1, Qi_CDB=tag, Qi_CDB_data=captured data, all held stable until grant.
  - A broadcast occurs in a cycle where Cdb_req and Cdb_grant are both 1.
  - At that edge, go to HOLD with cnt=HOLDOFF-1, and drive Cdb_req=0, Qi_CDB=3'b000, Qi_CDB_data=16'hFFF0, Rs_free=1.
- HOLD: Rs_free=1 only in the first HOLD cycle. Ready_to_uf is ignored. When cnt==0, go to IDLE; otherwise decrement.
- Uf_busy=1 in every state except IDLE.
- Ready_to_uf is ignored in all states other than IDLE.
- A Cdb_grant arriving while not in CDB is ignored.

## Timing
- Reset values: state IDLE, Mem_rd=0, Mem_addr=0, Cdb_req=0, Qi_CDB=3'b000, Qi_CDB_data=16'hFFF0, Uf_busy=0, Rs_free=0, cnt=0.
- Reset mid-operation: return to IDLE immediately. The in-flight load is dropped with no broadcast and no Rs_free.
- With accept at edge E0, MEM_LATENCY=L, and grant on first request:
  - Mem_rd is high in cycle E0–E1.
  - Data is sampled at edge E(1+L).
  - Cdb_req and the broadcast occur in the cycle after E(1+L).
  - Rs_free is high in the following cycle.
  - The earliest next accept is at edge E(3+L+HOLDOFF).
- Grant withheld N cycles: Cdb_req and the outputs stay stable, and all later events shift by N.
- Address overflow wraps: Op1=16'hFFFF, Op2=16'h0002 gives Mem_addr=7'h01.

## Structure
- The shared package tomasulo_pkg holds:
  - the sentinels (DATA_NONE=16'hFFF0, TAG_NONE=3'b000, A_NONE=7'b1111000)
  - UFOP_LOAD=3'd5
  - the tag width
  - the uf_load state enum
- Single module; no sub-module is warranted. The latency and holdoff share one counter.

## Test plan
- Basic load (defaults): Ready_to_uf=1, Op1=16'h0010, Op2=16'h0005, Rs_tag=3'd2, memory[7'h15]=16'hBEEF → one Mem_rd at 7'h15; Cdb_req rises 2 cycles after accept. With Cdb_grant=1, Qi_CDB=2 and Qi_CDB_data=16'hBEEF for one cycle, then Rs_free for one cycle.
- Grant stall: same stimulus, Cdb_grant held low 3 cycles → Cdb_req, Qi_CDB=2, and Qi_CDB_data=16'hBEEF stable for 4 cycles; exactly one Rs_free pulse.
- Holdoff: Ready_to_uf kept high with the same operands through completion → no second Mem_rd until HOLDOFF cycles after Rs_free. A new request presented afterwards is accepted.
- Sentinel and tag rejection:
  - Op1=16'hFFF0 with Ready_to_uf=1 → stays IDLE; no Mem_rd, no Cdb_req.
  - Rs_tag=0 → same.
- Wrap and latency: MEM_LATENCY=3, Op1=16'hFFFF, Op2=16'h0002 → Mem_addr=7'h01; data sampled 3 cycles after the Mem_rd cycle.
- Reset mid-WAIT: assert Reset one cycle after Mem_rd → all outputs at reset values immediately; no Cdb_req and no Rs_free afterwards.
